// File: rtl/apb_fifo_pkg.sv
// rtl/apb_fifo_pkg.sv - register map offsets, field indices and bus data type
package apb_fifo_pkg;

  typedef logic [31:0] apb_data_t;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;
  localparam logic [3:0] ADDR_THRESH = 4'hC;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_LEVEL   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_UDF     = 4;
  localparam int STAT_CNT_LSB = 8;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_CLEAR  = 1;

endpackage

// File: rtl/apb_fifo_slave_if.sv
// rtl/apb_fifo_slave_if.sv - APB3 bus bundle between requester and the FIFO slave
interface apb_fifo_slave_if;
  import apb_fifo_pkg::*;

  logic       PSEL;
  logic       PENABLE;
  logic [3:0] PADDR;
  logic       PWRITE;
  apb_data_t  PWDATA;
  apb_data_t  PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  modport master (
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/sync_fifo_core.sv
// rtl/sync_fifo_core.sv - first-word fall-through FIFO with wrap-around pointers and clear
module sync_fifo_core #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A push into a full FIFO is still accepted when a pop frees the slot in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (do_push && !clr) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/apb_fifo_slave.sv
// rtl/apb_fifo_slave.sv - zero-wait APB3 slave fronting a FIFO with status, control and threshold irq
module apb_fifo_slave
  import apb_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_fifo_slave_if.slave  bus,
  output logic             irq
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              access;
  logic              wr;
  logic              rd;
  logic              sel_data;
  logic              sel_status;
  logic              sel_ctrl;
  logic              sel_thresh;
  logic              misaligned;
  logic              push;
  logic              pop;
  logic              clr;
  logic              ovf_hit;
  logic              udf_hit;
  logic              ctrl_wr;
  logic              thresh_wr;
  logic              full;
  logic              empty;
  logic              level;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] fifo_rdata;
  logic              irq_en;
  logic [CNT_W-1:0]  thresh;
  logic              ovf;
  logic              udf;
  logic              unused_pwdata;
  apb_data_t         rdata_bus;

  assign access     = bus.PSEL & bus.PENABLE;
  assign wr         = access & bus.PWRITE;
  assign rd         = access & ~bus.PWRITE;
  assign misaligned = (bus.PADDR[1:0] != 2'b00);
  assign sel_data   = (bus.PADDR == ADDR_DATA);
  assign sel_status = (bus.PADDR == ADDR_STATUS);
  assign sel_ctrl   = (bus.PADDR == ADDR_CTRL);
  assign sel_thresh = (bus.PADDR == ADDR_THRESH);

  assign push      = wr & sel_data & ~full;
  assign pop       = rd & sel_data & ~empty;
  assign ovf_hit   = wr & sel_data & full;
  assign udf_hit   = rd & sel_data & empty;
  assign ctrl_wr   = wr & sel_ctrl;
  assign thresh_wr = wr & sel_thresh;
  assign clr       = ctrl_wr & bus.PWDATA[CTRL_CLEAR];

  assign bus.PREADY  = access;
  assign bus.PSLVERR = ovf_hit | udf_hit | (wr & sel_status) | (access & misaligned);

  assign unused_pwdata = ^bus.PWDATA;

  sync_fifo_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .push    (push),
    .pop     (pop),
    .clr     (clr),
    .wdata   (bus.PWDATA[DATA_W-1:0]),
    .rdata   (fifo_rdata),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // A threshold above DEPTH can never be reached, so level simply stays low.
  assign level = (count >= thresh);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      irq_en <= 1'b0;
      thresh <= CNT_W'(1);
      ovf    <= 1'b0;
      udf    <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (ctrl_wr)   irq_en <= bus.PWDATA[CTRL_IRQ_EN];
      if (thresh_wr) thresh <= bus.PWDATA[CNT_W-1:0];
      if (clr) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end else begin
        if (ovf_hit) ovf <= 1'b1;
        if (udf_hit) udf <= 1'b1;
      end
      irq <= irq_en & (level | ovf | udf);
    end
  end

  // Reads are combinational from pre-commit state; misaligned offsets match no case item.
  always_comb begin
    rdata_bus = '0;
    if (rd) begin
      case (bus.PADDR)
        ADDR_DATA: begin
          if (!empty) rdata_bus[DATA_W-1:0] = fifo_rdata;
        end
        ADDR_STATUS: begin
          rdata_bus[STAT_EMPTY]                  = empty;
          rdata_bus[STAT_FULL]                   = full;
          rdata_bus[STAT_LEVEL]                  = level;
          rdata_bus[STAT_OVF]                    = ovf;
          rdata_bus[STAT_UDF]                    = udf;
          rdata_bus[STAT_CNT_LSB +: CNT_W]       = count;
        end
        ADDR_CTRL:   rdata_bus[CTRL_IRQ_EN] = irq_en;
        ADDR_THRESH: rdata_bus[CNT_W-1:0]   = thresh;
        default:     rdata_bus = '0;
      endcase
    end
  end

  assign bus.PRDATA = rdata_bus;

endmodule

// File: tb/tb_apb_fifo_slave.sv
// tb/tb_apb_fifo_slave.sv - scoreboard bench for apb_fifo_slave against a queue-based register model
module tb_apb_fifo_slave;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        chk_rd;
  } exp_t;

  logic PCLK;
  logic PRESETn;
  logic irq;

  apb_fifo_slave_if bus ();

  apb_fifo_slave #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus),
    .irq     (irq)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int   vectors    = 0;
  int   miscompares = 0;
  bit   mon_en     = 1'b0;
  exp_t sb[$];

  int unsigned mq[$];
  bit          m_ovf;
  bit          m_udf;
  bit          m_irq_en;
  int          m_thresh;
  logic        exp_irq;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    m_irq_en = 1'b0;
    m_thresh = 1;
  endfunction

  function automatic exp_t model_resp(logic [3:0] addr, bit wr);
    exp_t e;
    int   cnt;
    cnt      = mq.size();
    e.rd     = 32'h0;
    e.err    = 1'b0;
    e.chk_rd = !wr;
    if (addr[1:0] != 2'b00) begin
      e.err = 1'b1;
    end else begin
      case (addr)
        4'h0: begin
          if (wr) e.err = (cnt == DEPTH);
          else if (cnt == 0) e.err = 1'b1;
          else e.rd = mq[0];
        end
        4'h4: begin
          if (wr) e.err = 1'b1;
          else begin
            e.rd[0] = (cnt == 0);
            e.rd[1] = (cnt == DEPTH);
            e.rd[2] = (cnt >= m_thresh);
            e.rd[3] = m_ovf;
            e.rd[4] = m_udf;
            e.rd    = e.rd | (32'(cnt) << 8);
          end
        end
        4'h8:    if (!wr) e.rd[0] = m_irq_en;
        default: if (!wr) e.rd = 32'(m_thresh);
      endcase
    end
    return e;
  endfunction

  function automatic void model_commit(logic [3:0] addr, bit wr, logic [31:0] wdata);
    if (addr[1:0] != 2'b00) return;
    case (addr)
      4'h0: begin
        if (wr) begin
          if (mq.size() == DEPTH) m_ovf = 1'b1;
          else mq.push_back(wdata & 32'hFF);
        end else begin
          if (mq.size() == 0) m_udf = 1'b1;
          else void'(mq.pop_front());
        end
      end
      4'h8: begin
        if (wr) begin
          m_irq_en = wdata[0];
          if (wdata[1]) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
          end
        end
      end
      4'hC: if (wr) m_thresh = int'(wdata & ((32'd1 << CNT_W) - 1));
      default: ;
    endcase
  endfunction

  // irq is the registered view of the model state one clock later.
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) exp_irq <= 1'b0;
    else exp_irq <= m_irq_en && ((mq.size() >= m_thresh) || m_ovf || m_udf);
  end

  always @(negedge PCLK) begin
    if (mon_en) begin
      exp_t e;
      check("irq", {31'b0, irq}, {31'b0, exp_irq});
      if (bus.PSEL && bus.PENABLE) begin
        check("pready", {31'b0, bus.PREADY}, 32'h1);
        if (sb.size() == 0) begin
          check("unexpected_access", 32'h1, 32'h0);
        end else begin
          e = sb.pop_front();
          check("pslverr", {31'b0, bus.PSLVERR}, {31'b0, e.err});
          if (e.chk_rd) check("prdata", bus.PRDATA, e.rd);
        end
      end else begin
        check("idle_prdata", bus.PRDATA, 32'h0);
        check("idle_pslverr", {31'b0, bus.PSLVERR}, 32'h0);
      end
    end
  end

  task automatic xfer(input logic [3:0] addr, input bit wr, input logic [31:0] wdata);
    sb.push_back(model_resp(addr, wr));
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PADDR   = addr;
    bus.PWRITE  = wr;
    bus.PWDATA  = wdata;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    model_commit(addr, wr, wdata);
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge PCLK); #1;
    end
  endtask

  initial begin
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PADDR   = 4'h0;
    bus.PWRITE  = 1'b0;
    bus.PWDATA  = 32'h0;
    PRESETn     = 1'b0;
    model_reset();
    idle(3);
    PRESETn = 1'b1;
    mon_en  = 1'b1;
    idle(1);

    xfer(4'h4, 1'b0, 32'h0);

    for (int i = 0; i < DEPTH; i++) xfer(4'h0, 1'b1, 32'h11 + 32'(i));
    xfer(4'h4, 1'b0, 32'h0);
    xfer(4'h0, 1'b1, 32'hAA);
    xfer(4'h4, 1'b0, 32'h0);
    for (int i = 0; i < DEPTH; i++) xfer(4'h0, 1'b0, 32'h0);

    xfer(4'h0, 1'b0, 32'h0);
    xfer(4'h4, 1'b0, 32'h0);

    xfer(4'h8, 1'b1, 32'h2);
    xfer(4'h4, 1'b0, 32'h0);
    xfer(4'h8, 1'b0, 32'h0);

    xfer(4'hC, 1'b1, 32'h4);
    xfer(4'h8, 1'b1, 32'h1);
    for (int i = 0; i < 4; i++) xfer(4'h0, 1'b1, 32'($urandom));
    idle(2);
    xfer(4'h0, 1'b0, 32'h0);
    idle(2);

    xfer(4'h1, 1'b1, 32'h55);
    xfer(4'h4, 1'b1, 32'hFFFF_FFFF);
    xfer(4'h4, 1'b0, 32'h0);
    xfer(4'hC, 1'b0, 32'h0);
    xfer(4'h8, 1'b0, 32'h0);
    xfer(4'h6, 1'b0, 32'h0);

    xfer(4'h0, 1'b1, 32'h5A);
    xfer(4'hC, 1'b1, 32'h2);
    mon_en      = 1'b0;
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PADDR   = 4'hC;
    bus.PWRITE  = 1'b1;
    bus.PWDATA  = 32'h9;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    #2;
    PRESETn = 1'b0;
    model_reset();
    @(posedge PCLK); #1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    mon_en  = 1'b1;
    xfer(4'h4, 1'b0, 32'h0);
    xfer(4'h8, 1'b0, 32'h0);
    xfer(4'hC, 1'b0, 32'h0);
    xfer(4'h0, 1'b0, 32'h0);
    xfer(4'h4, 1'b0, 32'h0);

    for (int n = 0; n < 400; n++) begin
      int          sel;
      logic [3:0]  addr;
      bit          wr;
      logic [31:0] wdata;
      sel   = int'($urandom_range(0, 9));
      wr    = $urandom_range(0, 1) == 1;
      wdata = $urandom;
      case (sel)
        0, 1, 2, 3: addr = 4'h0;
        4:          addr = 4'h4;
        5: begin
          addr  = 4'h8;
          wdata = {30'b0, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1))};
        end
        6:          addr = 4'hC;
        7:          addr = 4'(($urandom_range(0, 3) << 2) | $urandom_range(1, 3));
        default: begin
          addr = 4'h0;
          wr   = 1'b1;
        end
      endcase
      xfer(addr, wr, wdata);
      if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 3)));
    end

    idle(3);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
